pipeline_branch_ctl: RTL

PIPELINE_BRANCH_CTL -- requirements
Module: pipeline_branch_ctl

---
 rtl/pipeline_branch_ctl_pkg.sv | 30 +++
 rtl/pipeline_branch_ctl_bht.sv | 37 +++
 rtl/pipeline_branch_ctl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipeline_branch_ctl_pkg.sv
// Shared constants for the branch control slice.
//   ctr_e    : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   state_e  : branch-control FSM states (IDLE/FLUSH)
//   ctr_next : saturating counter step toward the resolved outcome
package pipeline_branch_ctl_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CTR_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipeline_branch_ctl_bht.sv
// branch_history_table: array of 2-bit saturating prediction counters.
//   clock, reset : rising-edge clock, synchronous active-high reset (all -> WNT)
//   rd_idx       : combinational read index
//   rd_ctr       : counter at rd_idx (pre-update value, no write bypass)
//   wr_en        : apply one saturating step at wr_idx on the next edge
//   wr_idx       : entry to update
//   wr_taken     : 1 = step toward taken, 0 = step toward not-taken
module branch_history_table
    import pipeline_branch_ctl_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [ENTRIES-1:0][1:0] table_q;

    // Read straight from the registers: a same-cycle write is not visible
    // until the following cycle.
    assign rd_ctr = table_q[rd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_WNT;
        end else if (wr_en) begin
            table_q[wr_idx] <= ctr_next(table_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/pipeline_branch_ctl.sv
// pipeline_branch_ctl: bimodal branch predictor with mispredict flush control
// and resolution statistics.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   lookup_pc         : fetch PC; predict_taken is its combinational prediction
//   resolve_*         : resolved conditional branch from execute
//   mispredict        : accepted resolution whose outcome differs from prediction
//   flush             : squash IF/ID, FLUSH_CYCLES consecutive cycles per mispredict
//   branch_count      : saturating count of accepted resolutions
//   mispredict_count  : saturating count of mispredicts
module pipeline_branch_ctl
    import pipeline_branch_ctl_pkg::*;
#(
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           lookup_pc,
    output logic                  predict_taken,
    input  logic                  resolve_valid,
    input  logic [31:0]           resolve_pc,
    input  logic                  resolve_taken,
    input  logic                  resolve_predicted,
    output logic                  mispredict,
    output logic                  flush,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int         IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e           state, state_nxt;
    logic [2:0]       flush_cnt, flush_cnt_nxt;
    logic             accepted;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [1:0]       rd_ctr;
    logic             unused_pc;

    // Word-aligned PCs: bits [1:0] and everything above the index are dropped.
    assign rd_idx    = lookup_pc[IDX_W+1:2];
    assign wr_idx    = resolve_pc[IDX_W+1:2];
    assign unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                         resolve_pc[31:IDX_W+2], resolve_pc[1:0]};

    // Resolutions seen while flushing belong to the squashed wrong path.
    // The mispredict cycle itself is still IDLE, so it is accepted.
    assign accepted      = resolve_valid & (state == ST_IDLE) & ~reset;
    assign mispredict    = accepted & (resolve_taken ^ resolve_predicted);
    assign flush         = ~reset & (mispredict | (state == ST_FLUSH));
    // Depends only on table and FSM state, never on resolve_*.
    assign predict_taken = ~reset & (state == ST_IDLE) & rd_ctr[1];

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (accepted),
        .wr_idx   (wr_idx),
        .wr_taken (resolve_taken)
    );

    // flush_cnt holds the number of FLUSH-state cycles still to run, the
    // current one included; the mispredict cycle itself is the first flush
    // cycle, so FLUSH_CYCLES-1 cycles remain when FLUSH is entered.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            ST_IDLE: begin
                if (mispredict && (FLUSH_LOAD != 3'd0)) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt <= 3'd1) begin
                    state_nxt     = ST_IDLE;
                    flush_cnt_nxt = 3'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (accepted && !(&branch_count))
                branch_count <= branch_count + 1'b1;
            if (mispredict && !(&mispredict_count))
                mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule
